fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS core. It holds the PC, selects the next PC from sequential, branch, jump and jump-register sources resolved in Decode, and drives the instruction memory. It presents the fetched instruction to Decode. It sits directly upstream of the hazard unit's Decode checks and obeys that unit's StallF/StallD outputs. It converts taken control transfers and instruction-memory wait cycles into bubbles.

---
 rtl/mips_pkg.sv | 41 ++++
 rtl/fetch_stage_if.sv | 27 ++
 rtl/if_id_reg.sv | 35 +++
 rtl/fetch_stage.sv | 104 ++++++++++
 tb/tb_fetch_stage.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core.
//
// Contents:
//   NOP_INSTR        - all-zero word (sll $0,$0,0) placed in Decode on a bubble
//   DEFAULT_RESET_PC - PC loaded on reset unless the core overrides it
//   JUMP_*_W         - field widths of the j/jal target construction
//   pc_sel_e         - next-PC source selector
//   if_id_t          - contents of the IF/ID pipeline register
//   jump_target()    - builds a j/jal target from the PC region and the index field
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int JUMP_INDEX_W  = 26;
    localparam int JUMP_REGION_W = 4;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_JR     = 2'd3
    } pc_sel_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

    // Target stays inside the 256 MB region of the instruction after the jump.
    function automatic logic [31:0] jump_target(
        input logic [JUMP_REGION_W-1:0] region,
        input logic [JUMP_INDEX_W-1:0]  index
    );
        return {region, index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
//
// Signals:
//   imem_addr  - fetch address (the PC register output)
//   imem_rdata - instruction word at imem_addr
//   imem_valid - imem_rdata holds a valid word this cycle
//
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_stage_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold and flush.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset, loads a bubble
//   enable - 0 holds the current contents (hold beats flush)
//   flush  - load a bubble instead of d
//   d      - fetched instruction, its PC+4 and valid flag
//   q      - registered contents presented to Decode
module if_id_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   enable,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= IF_ID_BUBBLE;
        end else if (enable) begin
            if (flush) begin
                q <= IF_ID_BUBBLE;
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID register.
//
// Ports:
//   clk, reset        - clock and asynchronous active-low reset
//   StallF, StallD    - hazard-unit holds for the PC and the IF/ID register
//   PCSrcD            - taken conditional branch in Decode, target PCBranchD
//   JumpD             - j/jal in Decode, target built from InstrD/PCPlus4D
//   jrD               - jr in Decode, target SrcAD (highest priority)
//   PCBranchD, SrcAD  - branch and jr targets from Decode
//   imem              - instruction-memory bus (master side)
//   PCF               - current fetch PC (same as imem.imem_addr)
//   InstrD, PCPlus4D  - instruction in Decode and its PC+4
//   ValidD            - 0 when Decode holds a bubble
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 StallF,
    input  logic                 StallD,
    input  logic                 PCSrcD,
    input  logic                 JumpD,
    input  logic                 jrD,
    input  logic [31:0]          PCBranchD,
    input  logic [31:0]          SrcAD,
    fetch_stage_if.master        imem,
    output logic [31:0]          PCF,
    output logic [31:0]          InstrD,
    output logic [31:0]          PCPlus4D,
    output logic                 ValidD
);

    logic [31:0] pc_q;
    logic [31:0] pc_plus4_f;
    logic [31:0] redirect_target;
    logic        redirect;
    pc_sel_e     pc_sel;
    if_id_t      fetch_word;
    if_id_t      if_id_q;

    assign pc_plus4_f = pc_q + 32'd4;

    // A stalled Decode stage holds a stale instruction, so its control
    // outputs must not steer the PC.
    assign redirect = (jrD | JumpD | PCSrcD) & ~StallD;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pc_sel = PC_SEQ;
        if (jrD) begin
            pc_sel = PC_JR;
        end else if (JumpD) begin
            pc_sel = PC_JUMP;
        end else if (PCSrcD) begin
            pc_sel = PC_BRANCH;
        end
    end

    always_comb begin
        redirect_target = pc_plus4_f;
        case (pc_sel)
            PC_JR:     redirect_target = SrcAD;
            PC_JUMP:   redirect_target = jump_target(PCPlus4D[31:32-JUMP_REGION_W],
                                                     InstrD[JUMP_INDEX_W-1:0]);
            PC_BRANCH: redirect_target = PCBranchD;
            default:   redirect_target = pc_plus4_f;
        endcase
    end

    // A redirect abandons an outstanding fetch even while imem is still busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else if (!StallF) begin
            if (redirect) begin
                pc_q <= redirect_target;
            end else if (imem.imem_valid) begin
                pc_q <= pc_plus4_f;
            end
        end
    end

    assign PCF            = pc_q;
    assign imem.imem_addr = pc_q;

    assign fetch_word = '{instr: imem.imem_rdata, pc_plus4: pc_plus4_f, valid: 1'b1};

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .reset  (reset),
        .enable (~StallD),
        .flush  (redirect | ~imem.imem_valid),
        .d      (fetch_word),
        .q      (if_id_q)
    );

    assign InstrD   = if_id_q.instr;
    assign PCPlus4D = if_id_q.pc_plus4;
    assign ValidD   = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// The instruction memory is a combinational function of the address; the word
// at 0x0040000C is a j whose index field 26'h0100040 targets 0x00400100.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic        StallF;
    logic        StallD;
    logic        PCSrcD;
    logic        JumpD;
    logic        jrD;
    logic [31:0] PCBranchD;
    logic [31:0] SrcAD;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        mem_valid;

    int n_chk;
    int n_err;

    fetch_stage_if imem ();

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0040_000C) return 32'h0810_0040;
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem.imem_rdata = mem(imem.imem_addr);
    assign imem.imem_valid = mem_valid;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk       (clk),
        .reset     (reset),
        .StallF    (StallF),
        .StallD    (StallD),
        .PCSrcD    (PCSrcD),
        .JumpD     (JumpD),
        .jrD       (jrD),
        .PCBranchD (PCBranchD),
        .SrcAD     (SrcAD),
        .imem      (imem),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Redirect the PC via jr and let the target reach Decode.
    // Afterwards: PCF=a+4, InstrD=mem(a), PCPlus4D=a+4, ValidD=1.
    task automatic goto_pc(input logic [31:0] a);
        jrD = 1'b1; SrcAD = a;
        step();
        jrD = 1'b0; SrcAD = 32'h0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0; StallF = 0; StallD = 0; PCSrcD = 0; JumpD = 0; jrD = 0;
        PCBranchD = 0; SrcAD = 0; mem_valid = 1'b1;
        step(); step();
        n_chk++; if (PCF !== RST_PC) begin n_err++; $display("FAIL reset_pcf: got %h want %h", PCF, RST_PC); end
        n_chk++; if (InstrD !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", InstrD); end
        n_chk++; if (PCPlus4D !== 32'h0) begin n_err++; $display("FAIL reset_pcplus4: got %h want 0", PCPlus4D); end
        n_chk++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ValidD); end
        @(negedge clk); reset = 1'b1;
        step();
        n_chk++; if (PCF !== 32'h0040_0004) begin n_err++; $display("FAIL seq1_pcf: got %h want 00400004", PCF); end
        n_chk++; if (InstrD !== mem(32'h0040_0000)) begin n_err++; $display("FAIL seq1_instr: got %h want %h", InstrD, mem(32'h0040_0000)); end
        n_chk++; if (PCPlus4D !== 32'h0040_0004) begin n_err++; $display("FAIL seq1_pcplus4: got %h want 00400004", PCPlus4D); end
        n_chk++; if (ValidD !== 1'b1) begin n_err++; $display("FAIL seq1_valid: got %b want 1", ValidD); end
        step();
        n_chk++; if (PCF !== 32'h0040_0008) begin n_err++; $display("FAIL seq2_pcf: got %h want 00400008", PCF); end
        n_chk++; if (InstrD !== mem(32'h0040_0004)) begin n_err++; $display("FAIL seq2_instr: got %h want %h", InstrD, mem(32'h0040_0004)); end
    endtask

    task automatic test_branch();
        PCSrcD = 1'b1; PCBranchD = 32'h0040_0100;
        step();
        PCSrcD = 1'b0; PCBranchD = 32'h0;
        n_chk++; if (PCF !== 32'h0040_0100) begin n_err++; $display("FAIL br_pcf: got %h want 00400100", PCF); end
        n_chk++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL br_bubble_valid: got %b want 0", ValidD); end
        n_chk++; if (InstrD !== 32'h0) begin n_err++; $display("FAIL br_bubble_instr: got %h want 0", InstrD); end
        step();
        n_chk++; if (InstrD !== mem(32'h0040_0100)) begin n_err++; $display("FAIL br_target_instr: got %h want %h", InstrD, mem(32'h0040_0100)); end
        n_chk++; if (PCPlus4D !== 32'h0040_0104) begin n_err++; $display("FAIL br_target_pcplus4: got %h want 00400104", PCPlus4D); end
        n_chk++; if (ValidD !== 1'b1) begin n_err++; $display("FAIL br_target_valid: got %b want 1", ValidD); end
    endtask

    task automatic test_jump();
        goto_pc(32'h0040_000C);
        n_chk++; if (InstrD !== 32'h0810_0040) begin n_err++; $display("FAIL j_decode_instr: got %h want 08100040", InstrD); end
        n_chk++; if (PCPlus4D !== 32'h0040_0010) begin n_err++; $display("FAIL j_decode_pcplus4: got %h want 00400010", PCPlus4D); end
        JumpD = 1'b1;
        step();
        JumpD = 1'b0;
        n_chk++; if (PCF !== 32'h0040_0100) begin n_err++; $display("FAIL j_pcf: got %h want 00400100", PCF); end
        n_chk++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL j_bubble: got %b want 0", ValidD); end
        step();
        n_chk++; if (InstrD !== mem(32'h0040_0100)) begin n_err++; $display("FAIL j_target_instr: got %h want %h", InstrD, mem(32'h0040_0100)); end
    endtask

    task automatic test_jr();
        jrD = 1'b1; JumpD = 1'b1; PCSrcD = 1'b1; SrcAD = 32'h0040_0200; PCBranchD = 32'h0040_0300;
        step();
        jrD = 1'b0; JumpD = 1'b0; PCSrcD = 1'b0; SrcAD = 32'h0; PCBranchD = 32'h0;
        n_chk++; if (PCF !== 32'h0040_0200) begin n_err++; $display("FAIL jr_pcf: got %h want 00400200", PCF); end
        n_chk++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL jr_bubble: got %b want 0", ValidD); end
        step();
        n_chk++; if (InstrD !== mem(32'h0040_0200)) begin n_err++; $display("FAIL jr_target_instr: got %h want %h", InstrD, mem(32'h0040_0200)); end
        n_chk++; if (PCPlus4D !== 32'h0040_0204) begin n_err++; $display("FAIL jr_target_pcplus4: got %h want 00400204", PCPlus4D); end
    endtask

    task automatic test_stall();
        goto_pc(32'h0040_0040);
        StallF = 1'b1; StallD = 1'b1; PCSrcD = 1'b1; PCBranchD = 32'h0040_0500;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++; if (PCF !== 32'h0040_0044) begin n_err++; $display("FAIL stall%0d_pcf: got %h want 00400044", i, PCF); end
            n_chk++; if (InstrD !== mem(32'h0040_0040)) begin n_err++; $display("FAIL stall%0d_instr: got %h want %h", i, InstrD, mem(32'h0040_0040)); end
            n_chk++; if (ValidD !== 1'b1) begin n_err++; $display("FAIL stall%0d_valid: got %b want 1", i, ValidD); end
        end
        StallF = 1'b0; StallD = 1'b0;
        step();
        PCSrcD = 1'b0; PCBranchD = 32'h0;
        n_chk++; if (PCF !== 32'h0040_0500) begin n_err++; $display("FAIL stall_release_pcf: got %h want 00400500", PCF); end
        n_chk++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL stall_release_bubble: got %b want 0", ValidD); end
        step();
        n_chk++; if (InstrD !== mem(32'h0040_0500)) begin n_err++; $display("FAIL stall_release_instr: got %h want %h", InstrD, mem(32'h0040_0500)); end
    endtask

    task automatic test_mem_wait();
        goto_pc(32'h0040_0080);
        mem_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_chk++; if (PCF !== 32'h0040_0084) begin n_err++; $display("FAIL wait%0d_pcf: got %h want 00400084", i, PCF); end
            n_chk++; if (InstrD !== 32'h0) begin n_err++; $display("FAIL wait%0d_instr: got %h want 0", i, InstrD); end
            n_chk++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL wait%0d_valid: got %b want 0", i, ValidD); end
        end
        mem_valid = 1'b1;
        step();
        n_chk++; if (PCF !== 32'h0040_0088) begin n_err++; $display("FAIL wait_done_pcf: got %h want 00400088", PCF); end
        n_chk++; if (InstrD !== mem(32'h0040_0084)) begin n_err++; $display("FAIL wait_done_instr: got %h want %h", InstrD, mem(32'h0040_0084)); end
        n_chk++; if (PCPlus4D !== 32'h0040_0088) begin n_err++; $display("FAIL wait_done_pcplus4: got %h want 00400088", PCPlus4D); end
        mem_valid = 1'b0; PCSrcD = 1'b1; PCBranchD = 32'h0040_0600;
        step();
        PCSrcD = 1'b0; PCBranchD = 32'h0; mem_valid = 1'b1;
        n_chk++; if (PCF !== 32'h0040_0600) begin n_err++; $display("FAIL wait_redirect_pcf: got %h want 00400600", PCF); end
        n_chk++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL wait_redirect_valid: got %b want 0", ValidD); end
        step();
        n_chk++; if (InstrD !== mem(32'h0040_0600)) begin n_err++; $display("FAIL wait_redirect_instr: got %h want %h", InstrD, mem(32'h0040_0600)); end
    endtask

    task automatic test_stallf_only();
        goto_pc(32'h0040_00C0);
        StallF = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_chk++; if (PCF !== 32'h0040_00C4) begin n_err++; $display("FAIL sf%0d_pcf: got %h want 004000c4", i, PCF); end
            n_chk++; if (InstrD !== mem(32'h0040_00C4)) begin n_err++; $display("FAIL sf%0d_instr: got %h want %h", i, InstrD, mem(32'h0040_00C4)); end
            n_chk++; if (PCPlus4D !== 32'h0040_00C8) begin n_err++; $display("FAIL sf%0d_pcplus4: got %h want 004000c8", i, PCPlus4D); end
        end
        StallF = 1'b0;
        step();
        n_chk++; if (PCF !== 32'h0040_00C8) begin n_err++; $display("FAIL sf_release_pcf: got %h want 004000c8", PCF); end
    endtask

    task automatic test_wrap();
        goto_pc(32'hFFFF_FFFC);
        n_chk++; if (PCF !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_pcf: got %h want 00000000", PCF); end
        n_chk++; if (InstrD !== mem(32'hFFFF_FFFC)) begin n_err++; $display("FAIL wrap_instr: got %h want %h", InstrD, mem(32'hFFFF_FFFC)); end
        n_chk++; if (PCPlus4D !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_pcplus4: got %h want 00000000", PCPlus4D); end
    endtask

    task automatic test_async_reset();
        goto_pc(32'h0040_0300);
        #2;
        reset = 1'b0;
        #1;
        n_chk++; if (PCF !== RST_PC) begin n_err++; $display("FAIL areset_pcf: got %h want %h", PCF, RST_PC); end
        n_chk++; if (InstrD !== 32'h0) begin n_err++; $display("FAIL areset_instr: got %h want 0", InstrD); end
        n_chk++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b want 0", ValidD); end
        @(negedge clk); reset = 1'b1;
        step();
        n_chk++; if (PCF !== 32'h0040_0004) begin n_err++; $display("FAIL areset_resume_pcf: got %h want 00400004", PCF); end
        n_chk++; if (InstrD !== mem(32'h0040_0000)) begin n_err++; $display("FAIL areset_resume_instr: got %h want %h", InstrD, mem(32'h0040_0000)); end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        test_reset();
        test_branch();
        test_jump();
        test_jr();
        test_stall();
        test_mem_wait();
        test_stallf_only();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
